// File: rtl/lfu_pkg.sv
// Shared types, default sizes and helpers for the LFU victim selector.
// Optional early exit on a zero count: define LFU_EARLY_EXIT_EN.
package lfu_pkg;

  localparam int LFU_ADDR_W    = 10;
  localparam int LFU_CNT_W     = 4;
  localparam int LFU_MAX_LINES = 64;
  localparam int LFU_IDX_W     = 6;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    REPORT
  } lfu_state_e;

  function automatic logic [LFU_MAX_LINES-1:0] onehot(input logic [LFU_IDX_W-1:0] index);
    logic [LFU_MAX_LINES-1:0] v;
    v        = '0;
    v[index] = 1'b1;
    return v;
  endfunction

  // Callers pad unused upper bits with ones so they never win.
  function automatic logic [LFU_IDX_W-1:0] lowest_zero_index(input logic [LFU_MAX_LINES-1:0] mask);
    logic [LFU_IDX_W-1:0] r;
    r = '0;
    for (int i = LFU_MAX_LINES - 1; i >= 0; i--) begin
      if (!mask[i]) r = LFU_IDX_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/lfu_min_cmp.sv
// Running-minimum step for the LFU scan: keeps the smaller count, earlier line on a tie.
module lfu_min_cmp #(
  parameter int CNT_W = 4,
  parameter int IDX_W = 4
) (
  input  logic [CNT_W-1:0] cur_cnt,
  input  logic [IDX_W-1:0] cur_idx,
  input  logic [CNT_W-1:0] min_cnt,
  input  logic [IDX_W-1:0] min_idx,
  output logic [CNT_W-1:0] new_min_cnt,
  output logic [IDX_W-1:0] new_min_idx
);

  // Candidates arrive in ascending line order, so strict less-than keeps the lowest index on ties.
  always_comb begin
    new_min_cnt = min_cnt;
    new_min_idx = min_idx;
    if (cur_cnt < min_cnt) begin
      new_min_cnt = cur_cnt;
      new_min_idx = cur_idx;
    end
  end

endmodule

// File: rtl/lfu_victim_selector.sv
// Picks the least-frequently-used (or first invalid) cache line for eviction.
// Optional early exit on a zero count: define LFU_EARLY_EXIT_EN.
module lfu_victim_selector
  import lfu_pkg::*;
#(
  parameter int ADDR_W = LFU_ADDR_W,
  parameter int CNT_W  = LFU_CNT_W
) (
  input  logic              clk,
  input  logic              gen_reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] valid_mask,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] victim_adress,
  output logic [CNT_W-1:0]  victim_count,
  output logic [ADDR_W-1:0] scan_adress,
  output logic              scan_count_read,
  input  logic [CNT_W-1:0]  count_in
);

  localparam int               IDX_W    = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ADDR_W - 1);

  lfu_state_e               state;
  logic [IDX_W-1:0]         index;
  logic [IDX_W-1:0]         min_idx;
  logic [CNT_W-1:0]         min_cnt;
  logic                     shortcut_hold;
  logic [IDX_W-1:0]         cmp_idx;
  logic [IDX_W-1:0]         zero_idx;
  logic [CNT_W-1:0]         new_min_cnt;
  logic [IDX_W-1:0]         new_min_idx;
  logic [LFU_MAX_LINES-1:0] mask_ext;
  logic                     all_valid;
`ifdef LFU_EARLY_EXIT_EN
  logic                     zero_hit;
`endif

  always_comb begin
    mask_ext             = '1;
    mask_ext[ADDR_W-1:0] = valid_mask;
  end

  assign all_valid = &valid_mask;
  assign zero_idx  = IDX_W'(lowest_zero_index(mask_ext));

  // The counter answers one cycle late: in SCAN count_in lags the issued index, in DRAIN it is the last line.
  assign cmp_idx = (state == DRAIN) ? LAST_IDX : index - IDX_W'(1);

`ifdef LFU_EARLY_EXIT_EN
  assign zero_hit = (index != '0) && (count_in == '0);
`endif

  lfu_min_cmp #(
    .CNT_W(CNT_W),
    .IDX_W(IDX_W)
  ) u_min_cmp (
    .cur_cnt    (count_in),
    .cur_idx    (cmp_idx),
    .min_cnt    (min_cnt),
    .min_idx    (min_idx),
    .new_min_cnt(new_min_cnt),
    .new_min_idx(new_min_idx)
  );

  always_ff @(posedge clk) begin
    if (gen_reset) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      scan_count_read <= 1'b0;
      scan_adress     <= '0;
      victim_adress   <= '0;
      victim_count    <= '0;
      index           <= '0;
      min_cnt         <= '1;
      min_idx         <= '0;
      shortcut_hold   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            busy  <= 1'b1;
            index <= '0;
            if (all_valid) begin
              state           <= SCAN;
              min_cnt         <= '1;
              min_idx         <= '0;
              scan_count_read <= 1'b1;
              scan_adress     <= ADDR_W'(onehot(LFU_IDX_W'(0)));
            end else begin
              state         <= REPORT;
              shortcut_hold <= 1'b1;
              min_cnt       <= '0;
              min_idx       <= zero_idx;
            end
          end
        end

        SCAN: begin
          if (index != '0) begin
            min_cnt <= new_min_cnt;
            min_idx <= new_min_idx;
          end
`ifdef LFU_EARLY_EXIT_EN
          if (zero_hit) begin
            state           <= REPORT;
            scan_count_read <= 1'b0;
            scan_adress     <= '0;
          end else
`endif
          if (index == LAST_IDX) begin
            state           <= DRAIN;
            scan_count_read <= 1'b0;
            scan_adress     <= '0;
          end else begin
            index       <= index + IDX_W'(1);
            scan_adress <= ADDR_W'(onehot(LFU_IDX_W'(index + IDX_W'(1))));
          end
        end

        DRAIN: begin
          min_cnt <= new_min_cnt;
          min_idx <= new_min_idx;
          state   <= REPORT;
        end

        REPORT: begin
          // An invalid-line pick spends one extra REPORT cycle so done lands two edges after the request.
          if (shortcut_hold) begin
            shortcut_hold <= 1'b0;
          end else begin
            done          <= 1'b1;
            busy          <= 1'b0;
            victim_adress <= ADDR_W'(onehot(LFU_IDX_W'(min_idx)));
            victim_count  <= min_cnt;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfu_victim_selector.sv
// Scoreboard bench for lfu_victim_selector with a behavioural counter and victim model.
module tb_lfu_victim_selector;

  localparam int N  = 10;
  localparam int CW = 4;

  logic          clk;
  logic          gen_reset;
  logic          req;
  logic [N-1:0]  valid_mask;
  logic          busy;
  logic          done;
  logic [N-1:0]  victim_adress;
  logic [CW-1:0] victim_count;
  logic [N-1:0]  scan_adress;
  logic          scan_count_read;
  logic [CW-1:0] count_in;

  typedef struct {
    logic [N-1:0]  vic;
    logic [CW-1:0] cnt;
    int            lat;
    int            strobes;
    int            start;
  } exp_t;

  exp_t          exq[$];
  exp_t          mon_e;
  logic [CW-1:0] cnt_tab[N];
  int            tests   = 0;
  int            fails   = 0;
  int            cyc     = 0;
  int            nstrobe = 0;
  bit            armed   = 0;

  lfu_victim_selector dut (
    .clk            (clk),
    .gen_reset      (gen_reset),
    .req            (req),
    .valid_mask     (valid_mask),
    .busy           (busy),
    .done           (done),
    .victim_adress  (victim_adress),
    .victim_count   (victim_count),
    .scan_adress    (scan_adress),
    .scan_count_read(scan_count_read),
    .count_in       (count_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [CW-1:0] read_count(input logic [N-1:0] a);
    for (int i = 0; i < N; i++) if (a[i]) return cnt_tab[i];
    return '1;
  endfunction

  // Frequency counter: count of the addressed line appears one cycle after the strobe.
  always @(posedge clk) begin
    if (scan_count_read === 1'b1) count_in <= read_count(scan_adress);
    else                          count_in <= CW'($urandom);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: first invalid line if any, else lowest-index line holding the minimum count.
  function automatic exp_t model(input logic [N-1:0] mask);
    exp_t e;
    int   minv;
    int   best;
    e.vic   = '0;
    e.cnt   = '0;
    e.start = 0;
    best    = 0;
    if (mask != '1) begin
      for (int i = N - 1; i >= 0; i--) if (!mask[i]) best = i;
      e.lat     = 2;
      e.strobes = 0;
    end else begin
      minv = 1 << CW;
      for (int i = 0; i < N; i++) if (int'(cnt_tab[i]) < minv) minv = int'(cnt_tab[i]);
      for (int i = N - 1; i >= 0; i--) if (int'(cnt_tab[i]) == minv) best = i;
      e.cnt     = CW'(minv);
      e.lat     = N + 2;
      e.strobes = N;
`ifdef LFU_EARLY_EXIT_EN
      if (minv == 0) begin
        e.lat     = best + 3;
        e.strobes = (best + 2 < N) ? best + 2 : N;
      end
`endif
    end
    e.vic[best] = 1'b1;
    return e;
  endfunction

  // Monitor: address walk on every cycle, scoreboard pop on every done.
  always @(negedge clk) begin
    if (armed) begin
      if (scan_count_read) begin
        if (nstrobe < N) chk("scan_adress_walk", 32'(scan_adress), 32'(1) << nstrobe);
        else             chk("strobe_overrun", nstrobe, N - 1);
        nstrobe++;
      end else begin
        chk("idle_scan_adress", 32'(scan_adress), 0);
      end
      if (done) begin
        if (exq.size() == 0) begin
          chk("unexpected_done", 32'(done), 0);
        end else begin
          mon_e = exq.pop_front();
          chk("victim_adress", 32'(victim_adress), 32'(mon_e.vic));
          chk("victim_count", 32'(victim_count), 32'(mon_e.cnt));
          chk("done_latency", cyc - mon_e.start, mon_e.lat);
          chk("strobe_count", nstrobe, mon_e.strobes);
          chk("busy_at_done", 32'(busy), 0);
        end
      end
      if (!busy) nstrobe = 0;
    end
  end

  task automatic issue(input logic [N-1:0] mask, input bit stray);
    exp_t e;
    bit   got;
    @(negedge clk);
    req        = 1'b1;
    valid_mask = mask;
    e          = model(mask);
    @(posedge clk);
    #1;
    req     = 1'b0;
    e.start = cyc;
    exq.push_back(e);
    chk("busy_after_accept", 32'(busy), 1);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (stray && i == 1 && busy) begin
        req        = 1'b1;
        valid_mask = N'($urandom);
      end else begin
        req = 1'b0;
      end
      if (done) got = 1'b1;
    end
    chk("done_seen", 32'(got), 1);
  endtask

  task automatic reset_and_check(input string tag);
    @(negedge clk);
    gen_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_victim_adress"}, 32'(victim_adress), 0);
    chk({tag, "_victim_count"}, 32'(victim_count), 0);
    chk({tag, "_scan_count_read"}, 32'(scan_count_read), 0);
    chk({tag, "_scan_adress"}, 32'(scan_adress), 0);
    @(negedge clk);
    gen_reset = 1'b0;
  endtask

  task automatic set_counts(input int lo, input int hi);
    for (int i = 0; i < N; i++) cnt_tab[i] = CW'($urandom_range(hi, lo));
  endtask

  initial begin
    gen_reset  = 1'b1;
    req        = 1'b0;
    valid_mask = '0;
    for (int i = 0; i < N; i++) cnt_tab[i] = '0;
    reset_and_check("reset");
    armed = 1'b1;

    // Full scan, minimum at line 2
    for (int i = 0; i < N; i++) cnt_tab[i] = 4'd7;
    cnt_tab[0] = 4'd3;
    cnt_tab[1] = 4'd5;
    cnt_tab[2] = 4'd1;
    issue('1, 1'b0);

    reset_and_check("idle_reset");

    // Ties and full saturation resolve to line 0
    for (int i = 0; i < N; i++) cnt_tab[i] = 4'd4;
    issue('1, 1'b0);
    for (int i = 0; i < N; i++) cnt_tab[i] = 4'd15;
    issue('1, 1'b0);

    // Invalid shortcut, with a stray req landing in REPORT
    set_counts(0, 15);
    issue(10'b1111110111, 1'b1);

    // Reset during the 5th SCAN cycle abandons the scan
    set_counts(1, 15);
    @(negedge clk);
    req        = 1'b1;
    valid_mask = '1;
    @(posedge clk);
    #1;
    req = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    gen_reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midscan_busy", 32'(busy), 0);
    chk("midscan_done", 32'(done), 0);
    chk("midscan_scan_count_read", 32'(scan_count_read), 0);
    @(negedge clk);
    gen_reset = 1'b0;
    set_counts(2, 9);
    cnt_tab[6] = 4'd1;
    issue('1, 1'b0);

    // Zero count at line 3
    set_counts(1, 15);
    cnt_tab[3] = 4'd0;
    issue('1, 1'b0);

    // Randomised traffic
    for (int t = 0; t < 40; t++) begin
      logic [N-1:0] m;
      case ($urandom_range(2, 0))
        0:       set_counts(0, 15);
        1:       set_counts(0, 2);
        default: set_counts(13, 15);
      endcase
      m = '1;
      if ($urandom_range(3, 0) == 0) m = N'($urandom);
      issue(m, ($urandom_range(2, 0) == 0));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish by %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lfu_victim_selector.md
Name: lfu_victim_selector

Overview:
Downstream consumer of the per-line LFU frequency counter. When the cache controller needs to evict, this block either picks an invalid line directly or scans every line's count through the counter's count-read port. It returns the one-hot address of the least-frequently-used line to the replacement logic. A single victim request is handled at a time through a req/busy/done handshake.

Parameters:
ADDR_W, 10, number of lines; width of the one-hot line address (lines 0..ADDR_W-1)
CNT_W, 4, width of a frequency count (matches the counter's count width)

Ports:
clk  input  1  clock; all state updates on rising edge
gen_reset  input  1  synchronous, active-high reset
req  input  1  victim request; sampled only in IDLE
valid_mask  input  ADDR_W  bit i = 1 when line i holds valid data; sampled with req
busy  output  1  high from the edge after req is accepted until done
done  output  1  one-cycle pulse; victim outputs are valid in that cycle
victim_adress  output  ADDR_W  one-hot victim line; held until the next accepted req
victim_count  output  CNT_W  count of the victim line; 0 for invalid-line picks
scan_adress  output  ADDR_W  one-hot address driven to the counter
scan_count_read  output  1  count-read strobe to the counter
count_in  input  CNT_W  counter's count_out; valid one cycle after the strobe/address

Behaviour:
- Reset: synchronous, active-high, on gen_reset. State goes to IDLE. busy, done, scan_count_read, scan_adress, victim_adress and victim_count all go to 0.
- Reset mid-operation: abandons the scan at the next edge with no done pulse. The bench may issue a new req in the cycle after reset drops.
- States: IDLE, SCAN, DRAIN, REPORT.
- IDLE:
  - req=1 with any valid_mask bit 0: go to REPORT with the invalid shortcut. Victim is the lowest-index invalid line, victim_count=0, no count reads. done is asserted 2 edges after the sampling edge.
  - req=1 with all lines valid: go to SCAN with index=0, min_cnt=all-ones, min_idx=0.
- SCAN:
  - Each cycle drives scan_count_read=1 and scan_adress=onehot(index), then increments index.
  - From the second SCAN cycle on, count_in belongs to index-1 and is compared against the running minimum.
  - Leaves for DRAIN after issuing index ADDR_W-1.
- DRAIN: strobe deasserted, last count_in compared, go to REPORT.
- REPORT: done=1, victim registers loaded, busy=0 at the next edge, back to IDLE.
- Latency: full scan has done high in the cycle starting ADDR_W+2 edges after the sampling edge (12 for ADDR_W=10).
- Compare rules:
  - Unsigned, strict less-than, so ties resolve to the lowest index.
  - A saturated count (all ones) is a legal candidate. If every line is saturated, the victim is line 0.
- Requests: req during busy is ignored, with no queueing. req held high in the REPORT cycle is not sampled, because the block is not in IDLE; it is sampled on the following IDLE cycle.
- Snapshot semantics: the counter may be written or read by the cache during a scan. The result reflects each count at the cycle it was read; there is no retry.
- Idle drive: when not in SCAN, scan_adress=0 and scan_count_read=0, so the controller can OR/mux the bus.

Optional Feature:
- LFU_EARLY_EXIT_EN defined: a count_in of 0 ends the scan immediately.
  - That line becomes the victim and the block goes straight to REPORT. DRAIN is skipped and the strobe is deasserted at once.
  - Line k found at zero gives done k+3 edges after req sampling.
- Undefined: every scan is the full ADDR_W+2-cycle scan; zero counts go through the normal compare.

Decomposition:
- Package lfu_pkg:
  - state enum (IDLE, SCAN, DRAIN, REPORT)
  - default ADDR_W/CNT_W constants
  - onehot(index) and lowest_zero_index(mask) functions
- Sub-module lfu_min_cmp: combinational (cur_cnt, cur_idx, min_cnt, min_idx) -> (new_min_cnt, new_min_idx). It holds the strict-less-than/tie rule so the rule can be reused by the cache's replacement checker.

Test Plan:
- Reset: hold gen_reset for 2 cycles mid-idle -> busy=0, done=0, victim_adress=0, scan_count_read=0, scan_adress=0.
- Full scan: valid_mask=all ones; counts line0=3, line1=5, line2=1, lines3-9=7 -> scan_adress walks 'b0000000001..'b1000000000; done at req+12; victim_adress='b0000000100, victim_count=1.
- Tie: all counts=4 -> victim_adress='b0000000001, victim_count=4. All counts=15 -> victim line 0, count 15.
- Invalid shortcut: valid_mask=10'b1111110111 -> no scan_count_read pulses; done at req+2; victim_adress='b0000001000, victim_count=0.
- Reset mid-scan: gen_reset at the 5th SCAN cycle -> no done, busy=0 after the next edge; a new req then completes with the correct victim.
- LFU_EARLY_EXIT_EN: line3=0, others nonzero -> done at req+6, victim_adress='b0000001000, victim_count=0. Without the macro -> done at req+12, same victim.
